kpn_split_ctrl: RTL

Sequencing controller for a KPN split node. It pops one token from the input channel FIFO, holds it, and delivers a copy to each of two output channel FIFOs. Each output is served independently under its own full-flag backpressure. A new token is read only after both copies are written, so a slow consumer stalls the node without losing or duplicating data. It sits between the upstream channel FIFO and the two downstream channel FIFOs, replacing free-running rd/wr toggling with real handshakes.

---
 rtl/kpn_split_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/kpn_split_ctrl.sv
// KPN split node sequencer: pops one token from the input channel FIFO and
// writes one copy to each of two output FIFOs under independent backpressure.
module kpn_split_ctrl #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_empty,
    output logic                  in_rd,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out1_full,
    output logic                  out1_wr,
    output logic [DATA_WIDTH-1:0] out1_data,
    input  logic                  out2_full,
    output logic                  out2_wr,
    output logic [DATA_WIDTH-1:0] out2_data,
    output logic                  busy,
    output logic [15:0]           token_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        LATCH    = 2'd2,
        DISPATCH = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] token_q;
    logic                  done1;
    logic                  done2;
    logic [CNT_W-1:0]      count_q;
    logic                  disp_c;
    logic                  exit_c;

    // Write strobes follow the full flags in the same cycle; reset suppresses them.
    assign disp_c  = (state == DISPATCH) && !rst;
    assign out1_wr = disp_c && !done1 && !out1_full;
    assign out2_wr = disp_c && !done2 && !out2_full;
    assign exit_c  = disp_c && (done1 || out1_wr) && (done2 || out2_wr);

    assign out1_data   = token_q;
    assign out2_data   = token_q;
    assign token_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            token_q <= '0;
            done1   <= 1'b0;
            done2   <= 1'b0;
            count_q <= '0;
            in_rd   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!in_empty) begin
                        state <= FETCH;
                        in_rd <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                    in_rd <= 1'b0;
                end
                LATCH: begin
                    token_q <= in_data;
                    done1   <= 1'b0;
                    done2   <= 1'b0;
                    state   <= DISPATCH;
                end
                DISPATCH: begin
                    if (out1_wr) done1 <= 1'b1;
                    if (out2_wr) done2 <= 1'b1;
                    // Both copies delivered: count the token and look for the next one.
                    if (exit_c) begin
                        count_q <= count_q + CNT_W'(1);
                        if (!in_empty) begin
                            state <= FETCH;
                            in_rd <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    in_rd <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
